des_gate_sched: RTL and testbench
=================================

// Module: des_gate_sched
// PURPOSE
// - Round-robin scheduler that shares one des_rw gate-evaluation unit between N task sources (CQ slices).
// - Sits between the task-dispatch side and the gate RW stage.
// - Keeps a small in-flight table so no two tasks for the same gate (locale) are in the RW pipeline at once.
//   Two in-flight tasks on one gate would read stale input/output state.
// PARAMETERS
// - N_REQ     4  number of requesting sources
// - INFLIGHT  8  max tasks issued but not yet completed; TAG_W = $clog2(INFLIGHT)
// - TILE_ID   0  tile index, used in simulation display only
// PORTS
// - clk            in   1             clock
// - rstn           in   1             synchronous active-low reset
// - req_valid      in   N_REQ         per-source task valid
// - req_ready      out  N_REQ         per-source accept; one-hot or zero
// - req_task       in   N_REQ*task_t  per-source task
// - req_cq_slot    in   N_REQ*cq_slice_slot_t  per-source CQ slot
// - out_valid      out  1             task to RW unit valid (registered)
// - out_ready      in   1             RW unit accepts
// - out_task       out  task_t        issued task
// - out_cq_slot    out  cq_slice_slot_t  issued CQ slot
// - out_src        out  $clog2(N_REQ) source index of issued task
// - out_tag        out  TAG_W         in-flight entry index of issued task
// - done_valid     in   1             RW unit finished a task
// - done_tag       in   TAG_W         tag of the finished task
// - log_output     out  32            stall-cycle counter
// - reg_bus        -    reg_bus_t     config writes
// BEHAVIOUR
// - Reset values: out_valid=0, req_ready=0, rr_ptr=0, all table entries invalid, stall counter=0,
//   err_bad_done=0, lock_en=1.
// - Config: write to DES_SCHED_CFG_ADDR (8'd56).
//   - wdata[0] = lock_en.
//   - wdata[1]=1 clears the stall counter and err_bad_done.
// - Eligibility of source i: req_valid[i], AND table not full, AND
//   (!lock_en OR req_task[i].locale matches no valid table entry).
//   - Matching uses the registered table state only.
// - Grant:
//   - Condition: load_en = !out_valid | out_ready.
//   - Winner: first eligible source scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready[g]=1 combinationally in the grant cycle only; never asserted while load_en=0.
// - On grant, at the next edge:
//   - out_* are loaded; out_valid=1; rr_ptr = (g+1) mod N_REQ.
//   - The lowest free table entry gets {valid=1, locale}; out_tag = that index.
// - On out_ready with no grant: out_valid=0. out_* is held stable while out_valid & !out_ready.
// - Latency: grant to out_valid is 1 cycle; back-to-back issue at 1 task/cycle for distinct locales.
// - Completion:
//   - done_valid clears entry done_tag at the edge.
//   - A waiting same-locale task is granted no earlier than the cycle after done (fixed 1-cycle bubble).
// - Simultaneous done and grant in one cycle: allowed. The allocated index is chosen from pre-done free entries.
// - done on an invalid entry: ignored; err_bad_done set sticky; $display in XILINX_SIMULATOR.
// - Table full: no grants. Stall counter still counts.
// - Same-cycle requests from two sources with the same locale: only one can win. The other becomes ineligible the next cycle.
// - Stall counter: +1 each cycle with |req_valid and no grant; saturates at 32'hFFFF_FFFF.
// - Reset mid-operation: all in-flight tracking discarded. The RW unit is reset by the same rstn.
// STRUCTURE
// - swarm package: DES_SCHED_CFG_ADDR; uses existing task_t and cq_slice_slot_t.
// - Sub-module des_inflight_table: valid/locale array.
//   - Outputs: CAM match vector, full flag, lowest-free index.
//   - Inputs: alloc port, free port.
// - Top: RR priority scan, output register, counter/config regs.
// TESTING
// - Single source, locales 5,6,7 on consecutive cycles, out_ready=1
//   -> out_valid 3 consecutive cycles; tags 0,1,2; src 0.
// - All 4 sources valid every cycle, distinct locales
//   -> grants in order 0,1,2,3,0...; each source gets 1 per 4 cycles.
// - Src0 locale 9 issued; src1 locale 9 requests; done_tag=0 asserted at cycle t
//   -> src1 granted at t+1, out_valid at t+2.
// - 8 tasks issued with no done -> req_ready stays 0 and stall counter increments;
//   one done -> next grant gets the freed tag.
// - out_ready=0 for 3 cycles while out_valid -> out_task/out_tag stable; no req_ready.
// - lock_en=0, two same-locale tasks back-to-back -> both issued on consecutive cycles.
// - done on a free tag -> err_bad_done=1; table unchanged.
// - rstn low mid-traffic -> next cycle out_valid=0, table empty, rr_ptr=0.

Source files
------------

// File: rtl/des_gate_sched_pkg.sv
// Shared types and constants for the gate scheduler: task/slot formats, the register bus,
// and the configuration address.
package des_gate_sched_pkg;

   localparam int LOCALE_W = 16;
   localparam logic [7:0] DES_SCHED_CFG_ADDR = 8'd56;

   typedef struct packed {
      logic [LOCALE_W-1:0] locale;
      logic [15:0]         arg;
   } task_t;

   typedef struct packed {
      logic [1:0] slice;
      logic [5:0] slot;
   } cq_slice_slot_t;

   typedef struct packed {
      logic        wr_en;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } reg_bus_t;

   function automatic logic cfg_hit(input reg_bus_t bus);
      return bus.wr_en && (bus.addr == DES_SCHED_CFG_ADDR);
   endfunction

endpackage

// File: rtl/des_inflight_table.sv
// In-flight table: one valid bit and locale per issued task. It provides a per-source match vector,
// a full flag, and the lowest free index.
module des_inflight_table
   import des_gate_sched_pkg::*;
#(
   parameter int INFLIGHT = 8,
   parameter int N_Q      = 4,
   localparam int TAG_W   = $clog2(INFLIGHT)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                alloc_en,
   input  logic [LOCALE_W-1:0] alloc_locale,
   input  logic                free_en,
   input  logic [TAG_W-1:0]    free_tag,
   input  logic [LOCALE_W-1:0] query_locale [N_Q],
   output logic [N_Q-1:0]      match,
   output logic                full,
   output logic [TAG_W-1:0]    free_idx,
   output logic [INFLIGHT-1:0] entry_valid
);

   logic [LOCALE_W-1:0] locale_q [INFLIGHT];

   // Free is applied before alloc. free_idx only points at an entry that was invalid
   // before this edge, so the two writes never collide on a live entry.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         entry_valid <= '0;
      end else begin
         if (free_en) entry_valid[free_tag] <= 1'b0;
         if (alloc_en) entry_valid[free_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_en) locale_q[free_idx] <= alloc_locale;
   end

   always_comb begin
      full     = &entry_valid;
      free_idx = '0;
      for (int i = INFLIGHT - 1; i >= 0; i--) begin
         if (!entry_valid[i]) free_idx = TAG_W'(i);
      end
   end

   always_comb begin
      match = '0;
      for (int q = 0; q < N_Q; q++) begin
         for (int i = 0; i < INFLIGHT; i++) begin
            if (entry_valid[i] && (locale_q[i] == query_locale[q])) match[q] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/des_gate_sched.sv
// Round-robin scheduler feeding one des_rw unit from N_REQ sources. It keeps at most one
// in-flight task per gate locale.
module des_gate_sched
   import des_gate_sched_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int INFLIGHT = 8,
   parameter int TILE_ID  = 0,
   localparam int TAG_W   = $clog2(INFLIGHT),
   localparam int SRC_W   = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  task_t                req_task [N_REQ],
   input  cq_slice_slot_t       req_cq_slot [N_REQ],
   output logic                 out_valid,
   input  logic                 out_ready,
   output task_t                out_task,
   output cq_slice_slot_t       out_cq_slot,
   output logic [SRC_W-1:0]     out_src,
   output logic [TAG_W-1:0]     out_tag,
   input  logic                 done_valid,
   input  logic [TAG_W-1:0]     done_tag,
   output logic [31:0]          log_output,
   output logic                 err_bad_done,
   input  reg_bus_t             reg_bus
);

   logic                lock_en;
   logic [SRC_W-1:0]    rr_ptr;
   logic [N_REQ-1:0]    match;
   logic [N_REQ-1:0]    eligible;
   logic                full;
   logic [TAG_W-1:0]    free_idx;
   logic [INFLIGHT-1:0] entry_valid;
   logic [LOCALE_W-1:0] query_locale [N_REQ];
   logic                load_en;
   logic                grant;
   logic [SRC_W-1:0]    grant_src;
   logic [SRC_W-1:0]    scan_idx;
   logic                cfg_wr;
   logic                cfg_clr;

   des_inflight_table #(
      .INFLIGHT (INFLIGHT),
      .N_Q      (N_REQ)
   ) u_table (
      .clk          (clk),
      .rstn         (rstn),
      .alloc_en     (grant),
      .alloc_locale (req_task[grant_src].locale),
      .free_en      (done_valid),
      .free_tag     (done_tag),
      .query_locale (query_locale),
      .match        (match),
      .full         (full),
      .free_idx     (free_idx),
      .entry_valid  (entry_valid)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         query_locale[i] = req_task[i].locale;
         eligible[i]     = req_valid[i] && !full && (!lock_en || !match[i]);
      end
   end

   assign load_en = !out_valid || out_ready;
   assign cfg_wr  = cfg_hit(reg_bus);
   assign cfg_clr = cfg_wr && reg_bus.wdata[1];

   // Scan starts at rr_ptr. Nothing is granted while reset is held or the output stage is stalled.
   always_comb begin
      grant     = 1'b0;
      grant_src = '0;
      scan_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = SRC_W'((int'(rr_ptr) + k) % N_REQ);
         if (!grant && rstn && load_en && eligible[scan_idx]) begin
            grant     = 1'b1;
            grant_src = scan_idx;
         end
      end
      req_ready = '0;
      if (grant) req_ready[grant_src] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid   <= 1'b0;
         out_task    <= '0;
         out_cq_slot <= '0;
         out_src     <= '0;
         out_tag     <= '0;
         rr_ptr      <= '0;
      end else if (grant) begin
         out_valid   <= 1'b1;
         out_task    <= req_task[grant_src];
         out_cq_slot <= req_cq_slot[grant_src];
         out_src     <= grant_src;
         out_tag     <= free_idx;
         rr_ptr      <= (int'(grant_src) == N_REQ - 1) ? '0 : grant_src + SRC_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lock_en      <= 1'b1;
         log_output   <= '0;
         err_bad_done <= 1'b0;
      end else begin
         if (cfg_wr) lock_en <= reg_bus.wdata[0];
         if (cfg_clr) begin
            log_output <= '0;
         end else if (|req_valid && !grant && (log_output != 32'hFFFF_FFFF)) begin
            log_output <= log_output + 32'd1;
         end
         if (cfg_clr) begin
            err_bad_done <= 1'b0;
         end else if (done_valid && !entry_valid[done_tag]) begin
            err_bad_done <= 1'b1;
         end
      end
   end

`ifdef XILINX_SIMULATOR
   always @(posedge clk) begin
      if (rstn && done_valid && !entry_valid[done_tag])
         $display("des_gate_sched tile %0d: done on free tag %0d", TILE_ID, done_tag);
   end
`endif

endmodule

// File: tb/tb_des_gate_sched.sv
// Bench for des_gate_sched. Issued tasks are checked against a queue of expected
// {src, tag, locale} records; grant timing and status outputs are checked inline.
module tb_des_gate_sched;
   import des_gate_sched_pkg::*;

   logic           clk = 1'b0;
   logic           rstn;
   logic [3:0]     req_valid;
   logic [3:0]     req_ready;
   task_t          req_task [4];
   cq_slice_slot_t req_cq_slot [4];
   logic           out_valid;
   logic           out_ready;
   task_t          out_task;
   cq_slice_slot_t out_cq_slot;
   logic [1:0]     out_src;
   logic [2:0]     out_tag;
   logic           done_valid;
   logic [2:0]     done_tag;
   logic [31:0]    log_output;
   logic           err_bad_done;
   reg_bus_t       reg_bus;

   des_gate_sched #(.N_REQ(4), .INFLIGHT(8), .TILE_ID(0)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_task     (req_task),
      .req_cq_slot  (req_cq_slot),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_task     (out_task),
      .out_cq_slot  (out_cq_slot),
      .out_src      (out_src),
      .out_tag      (out_tag),
      .done_valid   (done_valid),
      .done_tag     (done_tag),
      .log_output   (log_output),
      .err_bad_done (err_bad_done),
      .reg_bus      (reg_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [2:0]  tag;
      logic [15:0] locale;
   } exp_t;

   typedef struct {
      int          src;
      logic [15:0] locale;
      logic [2:0]  exp_tag;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] slot_of(input int s);
      return 8'(s * 64 + s + 8);
   endfunction

   // Every accepted output transfer must match the oldest outstanding expectation.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_issue", {30'd0, out_src}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("out_src", 32'(out_src), 32'(mon_e.src));
            check("out_tag", 32'(out_tag), 32'(mon_e.tag));
            check("out_locale", 32'(out_task.locale), 32'(mon_e.locale));
            check("out_cq_slot", 32'(out_cq_slot), 32'(slot_of(mon_e.src)));
         end
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      req_valid  = '0;
      done_valid = 1'b0;
      done_tag   = '0;
      out_ready  = 1'b1;
      reg_bus    = '0;
   endtask

   task automatic do_reset;
      idle();
      rstn = 1'b0;
      sb.delete();
      next_cycle();
      next_cycle();
      rstn = 1'b1;
   endtask

   task automatic cfg_write(input logic [31:0] d);
      reg_bus.wr_en = 1'b1;
      reg_bus.addr  = DES_SCHED_CFG_ADDR;
      reg_bus.wdata = d;
      next_cycle();
      reg_bus = '0;
   endtask

   task automatic drain_check(input string name);
      next_cycle();
      @(negedge clk);
      #1;
      check(name, 32'(sb.size()), 32'd0);
      next_cycle();
   endtask

   task automatic push_exp(input int s, input logic [2:0] t, input logic [15:0] l);
      exp_t e;
      e.src = s; e.tag = t; e.locale = l;
      sb.push_back(e);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v1[3];
      vec_t v2[8];

      for (int s = 0; s < 4; s++) begin
         req_task[s]    = '0;
         req_cq_slot[s] = cq_slice_slot_t'(slot_of(s));
      end
      idle();
      rstn = 1'b0;
      req_valid = 4'hF;
      next_cycle();
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_stall", log_output, 32'd0);
      check("rst_err", 32'(err_bad_done), 32'd0);
      next_cycle();

      // Single source, consecutive locales: tags 0,1,2 from src 0.
      do_reset();
      v1[0] = '{0, 16'd5, 3'd0};
      v1[1] = '{0, 16'd6, 3'd1};
      v1[2] = '{0, 16'd7, 3'd2};
      for (int i = 0; i < 3; i++) begin
         req_valid = 4'(1 << v1[i].src);
         req_task[v1[i].src].locale = v1[i].locale;
         push_exp(v1[i].src, v1[i].exp_tag, v1[i].locale);
         @(negedge clk);
         check("s1_ready", 32'(req_ready), 32'(1 << v1[i].src));
         next_cycle();
      end
      req_valid = '0;
      @(negedge clk);
      check("s1_out_valid", 32'(out_valid), 32'd1);
      drain_check("s1_drain");

      // Four sources, distinct locales: round-robin 0,1,2,3 until the table fills.
      do_reset();
      for (int j = 0; j < 8; j++) v2[j] = '{j % 4, 16'(100 + j), 3'(j)};
      for (int s = 0; s < 4; s++) req_task[s].locale = 16'(100 + s);
      req_valid = 4'hF;
      for (int j = 0; j < 8; j++) begin
         push_exp(v2[j].src, v2[j].exp_tag, v2[j].locale);
         @(negedge clk);
         check("s2_rr_ready", 32'(req_ready), 32'(1 << v2[j].src));
         next_cycle();
         req_task[v2[j].src].locale = 16'(100 + j + 4);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("s2_full_ready", 32'(req_ready), 32'd0);
         next_cycle();
      end
      done_valid = 1'b1;
      done_tag   = 3'd3;
      @(negedge clk);
      check("s2_done_cycle_ready", 32'(req_ready), 32'd0);
      next_cycle();
      done_valid = 1'b0;
      push_exp(0, 3'd3, 16'd108);
      @(negedge clk);
      check("s2_freed_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("s2_stall_cnt", log_output, 32'd4);
      drain_check("s2_drain");

      // Same locale waits for done, then exactly one bubble cycle.
      do_reset();
      req_valid = 4'b0001;
      req_task[0].locale = 16'd9;
      push_exp(0, 3'd0, 16'd9);
      @(negedge clk);
      check("s3_first_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 4'b0010;
      req_task[1].locale = 16'd9;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("s3_locked_ready", 32'(req_ready), 32'd0);
         next_cycle();
      end
      done_valid = 1'b1;
      done_tag   = 3'd0;
      @(negedge clk);
      check("s3_done_cycle_ready", 32'(req_ready), 32'd0);
      next_cycle();
      done_valid = 1'b0;
      push_exp(1, 3'd0, 16'd9);
      @(negedge clk);
      check("s3_after_done_ready", 32'(req_ready), 32'd2);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("s3_out_valid", 32'(out_valid), 32'd1);
      drain_check("s3_drain");

      // Backpressure: output held stable, no grants while stalled.
      do_reset();
      req_valid = 4'b0001;
      req_task[0].locale = 16'd30;
      push_exp(0, 3'd0, 16'd30);
      @(negedge clk);
      check("s4_first_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = 4'b0010;
      req_task[1].locale = 16'd31;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("s4_hold_valid", 32'(out_valid), 32'd1);
         check("s4_hold_tag", 32'(out_tag), 32'd0);
         check("s4_hold_locale", 32'(out_task.locale), 32'd30);
         check("s4_hold_ready", 32'(req_ready), 32'd0);
         next_cycle();
      end
      out_ready = 1'b1;
      push_exp(1, 3'd1, 16'd31);
      @(negedge clk);
      check("s4_release_ready", 32'(req_ready), 32'd2);
      next_cycle();
      req_valid = '0;
      drain_check("s4_drain");

      // Lock disabled, same locale twice; then a bad done and config clear.
      do_reset();
      cfg_write(32'd0);
      req_valid = 4'b0001;
      req_task[0].locale = 16'd40;
      for (int k = 0; k < 2; k++) begin
         push_exp(0, 3'(k), 16'd40);
         @(negedge clk);
         check("s5_nolock_ready", 32'(req_ready), 32'd1);
         next_cycle();
      end
      req_valid  = '0;
      done_valid = 1'b1;
      done_tag   = 3'd5;
      next_cycle();
      done_valid = 1'b0;
      @(negedge clk);
      check("s5_err_bad_done", 32'(err_bad_done), 32'd1);
      next_cycle();
      cfg_write(32'd1);
      req_valid = 4'b0100;
      req_task[2].locale = 16'd40;
      @(negedge clk);
      check("s5_relock_ready", 32'(req_ready), 32'd0);
      next_cycle();
      req_task[2].locale = 16'd41;
      push_exp(2, 3'd2, 16'd41);
      @(negedge clk);
      check("s5_free_tag_ready", 32'(req_ready), 32'd4);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("s5_stall_before_clr", log_output, 32'd1);
      next_cycle();
      cfg_write(32'd3);
      @(negedge clk);
      check("s5_err_cleared", 32'(err_bad_done), 32'd0);
      check("s5_stall_cleared", log_output, 32'd0);
      drain_check("s5_drain");

      // Reset in the middle of traffic.
      do_reset();
      for (int s = 0; s < 4; s++) req_task[s].locale = 16'(200 + s);
      req_valid = 4'hF;
      for (int j = 0; j < 3; j++) begin
         push_exp(j, 3'(j), 16'(200 + j));
         @(negedge clk);
         check("s6_pre_ready", 32'(req_ready), 32'(1 << j));
         next_cycle();
      end
      rstn = 1'b0;
      sb.delete();
      next_cycle();
      @(negedge clk);
      check("s6_rst_out_valid", 32'(out_valid), 32'd0);
      check("s6_rst_ready", 32'(req_ready), 32'd0);
      next_cycle();
      rstn = 1'b1;
      push_exp(0, 3'd0, 16'd200);
      @(negedge clk);
      check("s6_post_ready", 32'(req_ready), 32'd1);
      next_cycle();
      req_valid = '0;
      drain_check("s6_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
